// File: rtl/multiplier_unit_pkg.sv
// Shared definitions for multiplier_unit.
//   IN_W   : operand width
//   OUT_W  : product / memory word width (2*IN_W)
//   ADDR_W : memory address width
//   DEPTH  : words per block (2**ADDR_W)
//   state_t: controller states FILL, FULL, READ, DRAIN
package multiplier_unit_pkg;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 2 * IN_W;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/multiplier_unit.sv
// multiplier_unit
// Streams IN_W x IN_W products into an external DEPTH x OUT_W two-port SRAM,
// one product per clock, then reads the whole block back with a valid strobe.
// Memory port A is the read port, port B the write port; the memory's
// active-low chip enables are driven as cenA=~EN_readMem, cenB=~EN_writeMem.
//
// Optional build macro: MULT_SIGNED_EN -- operands are two's complement and
// the product is the signed OUT_W result. Undefined (default): unsigned.
//
// Ports:
//   CLK, RST       clock (rising edge), asynchronous active-high reset
//   EN_mult        operand pair valid; taken on an edge where RDY_mult=1
//   EN_blockRead   readout request, level, only looked at in FULL
//   mult_input0/1  operands
//   readMem_val    memory port-A read data, 1-cycle latency
//   RDY_mult       ready to accept an operand pair
//   EN_readMem     memory read enable (active-high)
//   EN_writeMem    memory write enable (active-high)
//   VALID_memVal   memVal_data carries a read word this cycle
//   writeMem_val   write data
//   memVal_data    readout data, 0 when not valid
//   writeMem_addr  write address
//   readMem_addr   read address
//   state_dbg      current controller state (state_t encoding)
//
// Handshake: a pair transfers on a rising edge where EN_mult=1 and RDY_mult=1;
// the producer may hold or change operands freely while RDY_mult=0. There is
// no back-pressure on the write or read-data paths.
module multiplier_unit
  import multiplier_unit_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN_mult,
  input  logic              EN_blockRead,
  input  logic [IN_W-1:0]   mult_input0,
  input  logic [IN_W-1:0]   mult_input1,
  input  logic [OUT_W-1:0]  readMem_val,
  output logic              RDY_mult,
  output logic              EN_readMem,
  output logic              EN_writeMem,
  output logic              VALID_memVal,
  output logic [OUT_W-1:0]  writeMem_val,
  output logic [OUT_W-1:0]  memVal_data,
  output logic [ADDR_W-1:0] writeMem_addr,
  output logic [ADDR_W-1:0] readMem_addr,
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rdy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OUT_W-1:0]  product;
  logic              rd_valid;
  logic              accept;
  logic [OUT_W-1:0]  product_next;

  // RDY_mult is a register, so a pair is only taken once the ready level
  // has actually been presented to the producer (first edge after reset).
  assign accept = (state == FILL) && rdy && EN_mult;

`ifdef MULT_SIGNED_EN
  assign product_next = $signed({{(OUT_W-IN_W){mult_input0[IN_W-1]}}, mult_input0})
                      * $signed({{(OUT_W-IN_W){mult_input1[IN_W-1]}}, mult_input1});
`else
  assign product_next = {{(OUT_W-IN_W){1'b0}}, mult_input0}
                      * {{(OUT_W-IN_W){1'b0}}, mult_input1};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rdy      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      product  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      // Read data comes back one cycle after each issue, so valid is simply
      // "were we issuing a read last cycle".
      rd_valid <= (state == READ);
      case (state)
        FILL: begin
          rdy <= 1'b1;
          if (accept) begin
            product <= product_next;
            wr_en   <= 1'b1;
            wr_addr <= wr_ptr;
            wr_ptr  <= wr_ptr + ONE_ADDR;
            // Last slot: the block is full; its write still issues next cycle.
            if (wr_ptr == LAST_ADDR) begin
              state <= FULL;
              rdy   <= 1'b0;
            end
          end
        end
        FULL: begin
          rdy <= 1'b0;
          if (EN_blockRead) state <= READ;
        end
        READ: begin
          rd_ptr <= rd_ptr + ONE_ADDR;
          if (rd_ptr == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          rd_ptr <= '0;
          rdy    <= 1'b1;
          state  <= FILL;
        end
        default: begin
          state <= FILL;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign RDY_mult      = rdy;
  assign EN_writeMem   = wr_en;
  assign writeMem_addr = wr_addr;
  assign writeMem_val  = product;
  assign EN_readMem    = (state == READ);
  assign readMem_addr  = rd_ptr;
  assign VALID_memVal  = rd_valid;
  assign memVal_data   = rd_valid ? readMem_val : '0;
  assign state_dbg     = state;

endmodule

// File: tb/tb_multiplier_unit.sv
// Testbench for multiplier_unit with a behavioural two-port 64x32 SRAM
// (1-cycle read latency) attached to its memory ports.
module tb_multiplier_unit;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_mult = 1'b0;
  logic        en_block_read = 1'b0;
  logic [15:0] mult_input0 = '0;
  logic [15:0] mult_input1 = '0;
  logic [31:0] read_mem_val;
  logic        rdy_mult, en_read_mem, en_write_mem, valid_mem_val;
  logic [31:0] write_mem_val, mem_val_data;
  logic [5:0]  write_mem_addr, read_mem_addr;
  logic [1:0]  state_dbg;

  multiplier_unit dut (
    .CLK          (clk),
    .RST          (rst),
    .EN_mult      (en_mult),
    .EN_blockRead (en_block_read),
    .mult_input0  (mult_input0),
    .mult_input1  (mult_input1),
    .readMem_val  (read_mem_val),
    .RDY_mult     (rdy_mult),
    .EN_readMem   (en_read_mem),
    .EN_writeMem  (en_write_mem),
    .VALID_memVal (valid_mem_val),
    .writeMem_val (write_mem_val),
    .memVal_data  (mem_val_data),
    .writeMem_addr(write_mem_addr),
    .readMem_addr (read_mem_addr),
    .state_dbg    (state_dbg)
  );

  // Behavioural SRAM: port B write, port A read with 1-cycle latency.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (en_write_mem) mem[write_mem_addr] <= write_mem_val;
    if (en_read_mem)  read_mem_val <= mem[read_mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wr_q[$];   // products expected on the write port, in order
  logic [31:0] exp_q[$];  // words expected on the readout, in order
  int wr_idx = 0;
  int valid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      wr_idx = 0;
    end else begin
      if (en_write_mem) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          check("wr_data", write_mem_val, wr_q.pop_front());
          check("wr_addr", {26'd0, write_mem_addr}, wr_idx);
          wr_idx = (wr_idx + 1) % 64;
        end
      end
      if (en_write_mem && en_read_mem) check("rw_overlap", 32'd1, 32'd0);
      if (valid_mem_val) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("rd_data", mem_val_data, exp_q.pop_front());
      end else if (mem_val_data !== 32'd0) begin
        check("rd_data_idle", mem_val_data, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic [31:0] prod);
    check("rdy_in_fill", {31'd0, rdy_mult}, 32'd1);
    mult_input0 = a;
    mult_input1 = b;
    en_mult = 1'b1;
    wr_q.push_back(prod);
    exp_q.push_back(prod);
    tick();
    en_mult = 1'b0;
  endtask

  // mode 0: first block (6*4, then i*2); otherwise pairs (i, k).
  task automatic fill(input int mode, input int k, input bit bubble);
    for (int i = 0; i < 64; i++) begin
      if (bubble && i == 20) begin
        en_block_read = 1'b1;
        for (int j = 0; j < 3; j++) begin
          tick();
          check("bubble_no_write", {31'd0, en_write_mem}, 32'd0);
          check("bubble_state", {30'd0, state_dbg}, {30'd0, ST_FILL});
        end
        en_block_read = 1'b0;
      end
      if (mode == 0) begin
        if (i == 0) push_pair(16'd6, 16'd4, 32'd24);
        else push_pair(16'(i - 1), 16'd2, 32'(2 * (i - 1)));
      end else if (k == 18 && i == 63) begin
`ifdef MULT_SIGNED_EN
        push_pair(16'hFFFF, 16'hFFFF, 32'h0000_0001);
`else
        push_pair(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
`endif
      end else begin
        push_pair(16'(i), 16'(k), 32'(i * k));
      end
    end
    check("rdy_after_fill", {31'd0, rdy_mult}, 32'd0);
    check("state_full", {30'd0, state_dbg}, {30'd0, ST_FULL});
  endtask

  task automatic readout();
    int start_cnt;
    int cycles;
    start_cnt = valid_cnt;
    cycles = 0;
    en_block_read = 1'b1;
    tick();
    en_block_read = 1'b0;
    check("state_read", {30'd0, state_dbg}, {30'd0, ST_READ});
    check("wr_q_drained", wr_q.size(), 32'd0);
    while (!(state_dbg == ST_FILL && rdy_mult) && cycles < 100) begin
      tick();
      cycles++;
    end
    check("read_len", cycles, 32'd65);
    check("valid_cnt", valid_cnt - start_cnt, 32'd64);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("rdy_after_drain", {31'd0, rdy_mult}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset: every output low while RST is asserted.
    tick(); tick();
    check("rst_rdy", {31'd0, rdy_mult}, 32'd0);
    check("rst_wen", {31'd0, en_write_mem}, 32'd0);
    check("rst_ren", {31'd0, en_read_mem}, 32'd0);
    check("rst_valid", {31'd0, valid_mem_val}, 32'd0);
    check("rst_wval", write_mem_val, 32'd0);
    check("rst_mdata", mem_val_data, 32'd0);
    check("rst_addrs", {20'd0, write_mem_addr, read_mem_addr}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_FILL});
    rst = 1'b0;
    #1;
    check("rdy_before_edge", {31'd0, rdy_mult}, 32'd0);
    tick();
    check("rdy_after_edge", {31'd0, rdy_mult}, 32'd1);

    // First block, then EN_mult held in FULL must be ignored.
    fill(0, 0, 1'b0);
    en_mult = 1'b1;
    tick(); tick();
    en_mult = 1'b0;
    check("full_ignores_mult", {31'd0, rdy_mult}, 32'd0);
    check("full_hold_state", {30'd0, state_dbg}, {30'd0, ST_FULL});
    readout();

    // Nine more blocks, k = 2..18 step 2; bubble + stray block-read in one.
    for (int k = 2; k <= 18; k += 2) begin
      fill(1, k, k == 4);
      readout();
    end

    // Reset in the middle of a readout.
    fill(1, 3, 1'b0);
    en_block_read = 1'b1;
    tick();
    en_block_read = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("midrd_valid", {31'd0, valid_mem_val}, 32'd0);
    check("midrd_ren", {31'd0, en_read_mem}, 32'd0);
    check("midrd_state", {30'd0, state_dbg}, {30'd0, ST_FILL});
    check("midrd_raddr", {26'd0, read_mem_addr}, 32'd0);
    exp_q.delete();
    wr_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_rdy", {31'd0, rdy_mult}, 32'd1);
    fill(1, 5, 1'b0);
    readout();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
